// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle raster front-end.
// Screen limits and frame-buffer address width live here.
package raster_pkg;

  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned FB_ADDR_W = 26;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] x2;
    logic [15:0] y2;
    logic [15:0] x3;
    logic [15:0] y3;
    logic [23:0] color1;
    logic [23:0] color2;
    logic [23:0] color3;
  } tri_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    SWAP
  } seq_state_t;

endpackage

// File: rtl/raster_sequencer_tri_fifo.sv
// Synchronous FIFO of triangle descriptors plus eof bit.
// Pointers carry an extra wrap bit to tell full from empty.
module tri_fifo #(
  parameter int unsigned W     = 169,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/raster_sequencer.sv
// Triangle issue scheduler with double-buffered frame bases.
// Define RAST_CLIP_EN to cull off-screen triangles (adds cull_count).
module raster_sequencer
  import raster_pkg::*;
#(
  parameter int unsigned           COORD_W  = 16,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [FB_ADDR_W-1:0]  FB_BASE0 = 26'h000_0000,
  parameter logic [FB_ADDR_W-1:0]  FB_BASE1 = 26'h004_B000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     tri_valid,
  output logic                     tri_ready,
  input  logic [6*COORD_W+71:0]    tri_data,
  input  logic                     tri_eof,
  output logic                     rast_start,
  output logic [6*COORD_W+71:0]    rast_tri,
  output logic [FB_ADDR_W-1:0]     rast_base,
  input  logic                     rast_done,
  output logic                     swap_req,
  input  logic                     swap_ack,
  output logic [FB_ADDR_W-1:0]     front_base,
  output logic                     busy,
  output logic [15:0]              tri_count
`ifdef RAST_CLIP_EN
  ,
  output logic [15:0]              cull_count
`endif
);

  localparam int unsigned TRI_W = 6*COORD_W+72;

  seq_state_t     state;
  seq_state_t     state_nx;
  logic [TRI_W:0] fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           eof_q;
  logic           done_ok;
  logic           ack_ok;
  logic           cull;

  tri_fifo #(
    .W     (TRI_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tri_valid),
    .pop   (pop),
    .wdata ({tri_data, tri_eof}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef RAST_CLIP_EN
  function automatic logic [COORD_W-1:0] min3(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  logic [COORD_W-1:0] min_x;
  logic [COORD_W-1:0] min_y;

  // Coordinates are packed x1,y1,x2,y2,x3,y3 from the MSB down.
  assign min_x = min3(rast_tri[TRI_W-1 -: COORD_W],
                      rast_tri[TRI_W-1-2*COORD_W -: COORD_W],
                      rast_tri[TRI_W-1-4*COORD_W -: COORD_W]);
  assign min_y = min3(rast_tri[TRI_W-1-COORD_W -: COORD_W],
                      rast_tri[TRI_W-1-3*COORD_W -: COORD_W],
                      rast_tri[TRI_W-1-5*COORD_W -: COORD_W]);
  assign cull  = (min_x >= COORD_W'(SCREEN_W)) ||
                 (min_y >= COORD_W'(SCREEN_H));
`else
  assign cull = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!fifo_empty) state_nx = LOAD;
      LOAD: begin
        if (cull)
          state_nx = eof_q ? SWAP : IDLE;
        else
          state_nx = RUN;
      end
      RUN:  if (rast_done) state_nx = eof_q ? SWAP : IDLE;
      SWAP: if (swap_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop        = (state == IDLE) && !fifo_empty;
    rast_start = (state == LOAD) && !cull;
    swap_req   = (state == SWAP);
    done_ok    = ((state == RUN) && rast_done) ||
                 ((state == LOAD) && cull);
    ack_ok     = (state == SWAP) && swap_ack;
  end

  assign tri_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rast_tri   <= '0;
      eof_q      <= 1'b0;
      rast_base  <= FB_BASE1;
      front_base <= FB_BASE0;
      tri_count  <= '0;
    end else begin
      if (pop) begin
        rast_tri <= fifo_rdata[TRI_W:1];
        eof_q    <= fifo_rdata[0];
      end
      if (done_ok)
        tri_count <= tri_count + 16'd1;
      if (ack_ok) begin
        rast_base  <= front_base;
        front_base <= rast_base;
      end
    end
  end

`ifdef RAST_CLIP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cull_count <= '0;
    else if ((state == LOAD) && cull)
      cull_count <= cull_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_raster_sequencer.sv
// Self-checking bench for raster_sequencer: vector table,
// directed corner sequences and a randomized reference-model run.
module tb_raster_sequencer;

  localparam int COORD_W = 16;
  localparam int DEPTH   = 4;
  localparam int TRI_W   = 6*COORD_W+72;
  localparam logic [25:0] FB0 = 26'h000_0000;
  localparam logic [25:0] FB1 = 26'h004_B000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             tri_valid;
  logic             tri_ready;
  logic [TRI_W-1:0] tri_data;
  logic             tri_eof;
  logic             rast_start;
  logic [TRI_W-1:0] rast_tri;
  logic [25:0]      rast_base;
  logic             rast_done;
  logic             swap_req;
  logic             swap_ack;
  logic [25:0]      front_base;
  logic             busy;
  logic [15:0]      tri_count;
`ifdef RAST_CLIP_EN
  logic [15:0]      cull_count;
`endif

  raster_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_data   (tri_data),
    .tri_eof    (tri_eof),
    .rast_start (rast_start),
    .rast_tri   (rast_tri),
    .rast_base  (rast_base),
    .rast_done  (rast_done),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .front_base (front_base),
    .busy       (busy),
    .tri_count  (tri_count)
`ifdef RAST_CLIP_EN
    ,
    .cull_count (cull_count)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: phase 0 idle, 1 load, 2 run, 3 swap
  logic [TRI_W:0]   mq [$];
  int               ph;
  logic [TRI_W-1:0] m_tri;
  bit               m_eof;
  logic [25:0]      m_front;
  logic [25:0]      m_back;
  logic [15:0]      m_cnt;
  logic [15:0]      m_cull;
  logic [TRI_W-1:0] started [$];

  typedef struct {
    bit          v;
    bit          done;
    bit          e_start;
    bit          e_ready;
    bit          e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic logic [TRI_W-1:0] mk(
    int x1, int y1, int x2, int y2, int x3, int y3, int c);
    return {16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'(x3), 16'(y3),
            24'(c), 24'(c + 1), 24'(c + 2)};
  endfunction

  function automatic int coord(logic [TRI_W-1:0] t, int k);
    logic [COORD_W-1:0] v;
    v = t[TRI_W-1-k*COORD_W -: COORD_W];
    return int'(v);
  endfunction

  function automatic bit culled(logic [TRI_W-1:0] t);
    int mx;
    int my;
    mx = coord(t, 0);
    my = coord(t, 1);
    if (coord(t, 2) < mx) mx = coord(t, 2);
    if (coord(t, 4) < mx) mx = coord(t, 4);
    if (coord(t, 3) < my) my = coord(t, 3);
    if (coord(t, 5) < my) my = coord(t, 5);
    return (mx >= 640) || (my >= 480);
  endfunction

  task automatic chk(input string nm,
                     input logic [TRI_W-1:0] act,
                     input logic [TRI_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    bit exp_start;
    exp_start = (ph == 1);
`ifdef RAST_CLIP_EN
    if (culled(m_tri)) exp_start = 1'b0;
    chk("m_cull", cull_count, m_cull);
`endif
    chk("m_ready", tri_ready, mq.size() < DEPTH);
    chk("m_start", rast_start, exp_start);
    chk("m_swap_req", swap_req, ph == 3);
    chk("m_busy", busy, (ph != 0) || (mq.size() != 0));
    chk("m_rast_tri", rast_tri, m_tri);
    chk("m_rast_base", rast_base, m_back);
    chk("m_front_base", front_base, m_front);
    chk("m_tri_count", tri_count, m_cnt);
  endtask

  task automatic model_step();
    bit          do_push;
    logic [25:0] t;
    do_push = tri_valid && (mq.size() < DEPTH);
    case (ph)
      0: if (mq.size() > 0) begin
        logic [TRI_W:0] e;
        e = mq.pop_front();
        m_tri = e[TRI_W:1];
        m_eof = e[0];
        ph = 1;
      end
      1: begin
        ph = 2;
`ifdef RAST_CLIP_EN
        if (culled(m_tri)) begin
          m_cnt++;
          m_cull++;
          ph = m_eof ? 3 : 0;
        end
`endif
      end
      2: if (rast_done) begin
        m_cnt++;
        ph = m_eof ? 3 : 0;
      end
      default: if (swap_ack) begin
        t = m_front;
        m_front = m_back;
        m_back = t;
        ph = 0;
      end
    endcase
    if (do_push) mq.push_back({tri_data, tri_eof});
  endtask

  task automatic tick();
    check_model();
    if (rast_start) started.push_back(rast_tri);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    tri_valid = 1'b0;
    tri_eof   = 1'b0;
    rast_done = 1'b0;
    swap_ack  = 1'b0;
    reset     = 1'b0;
    #1;
    chk("rst_start", rast_start, 0);
    chk("rst_swap_req", swap_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tri_ready, 1);
    chk("rst_count", tri_count, 0);
    chk("rst_rast_base", rast_base, FB1);
    chk("rst_front_base", front_base, FB0);
    chk("rst_rast_tri", rast_tri, 0);
`ifdef RAST_CLIP_EN
    chk("rst_cull", cull_count, 0);
`endif
    mq.delete();
    ph      = 0;
    m_tri   = '0;
    m_eof   = 1'b0;
    m_front = FB0;
    m_back  = FB1;
    m_cnt   = '0;
    m_cull  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!rast_start && k < 20) begin
      tick();
      k++;
    end
    chk(nm, rast_start, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t             tv [5];
    logic [TRI_W-1:0] t1;
    logic [TRI_W-1:0] exp_q [$];
    logic [15:0]      c0;
    logic [25:0]      f0;

    tri_valid = 1'b0;
    tri_data  = '0;
    tri_eof   = 1'b0;
    rast_done = 1'b0;
    swap_ack  = 1'b0;
    #2;
    do_reset();

    // single push into idle: start in cycle 2, count after done
    t1 = mk(10, 10, 50, 10, 30, 40, 24'h112233);
    tv[0] = '{1, 0, 0, 1, 0, 16'd0};
    tv[1] = '{0, 0, 0, 1, 1, 16'd0};
    tv[2] = '{0, 0, 1, 1, 1, 16'd0};
    tv[3] = '{0, 1, 0, 1, 1, 16'd0};
    tv[4] = '{0, 0, 0, 1, 0, 16'd1};
    for (int i = 0; i < 5; i++) begin
      tri_valid = tv[i].v;
      tri_data  = t1;
      rast_done = tv[i].done;
      chk($sformatf("t1_start_c%0d", i), rast_start, tv[i].e_start);
      chk($sformatf("t1_ready_c%0d", i), tri_ready, tv[i].e_ready);
      chk($sformatf("t1_busy_c%0d", i), busy, tv[i].e_busy);
      chk($sformatf("t1_count_c%0d", i), tri_count, tv[i].e_cnt);
      if (tv[i].e_start) begin
        chk("t1_rast_tri", rast_tri, t1);
        chk("t1_rast_base", rast_base, FB1);
      end
      tick();
    end
    rast_done = 1'b0;

    // eof triangle: swap_req holds until ack, then bases exchange
    tri_valid = 1'b1;
    tri_data  = mk(1, 2, 3, 4, 5, 6, 24'hABCDEF);
    tri_eof   = 1'b1;
    tick();
    tri_valid = 1'b0;
    tri_eof   = 1'b0;
    wait_start("t3_start");
    tick();
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_swap_hold", swap_req, 1);
      tick();
    end
    chk("t3_base_before", rast_base, FB1);
    swap_ack = 1'b1;
    tick();
    swap_ack = 1'b0;
    chk("t3_swap_clr", swap_req, 0);
    chk("t3_front", front_base, FB1);
    chk("t3_back", rast_base, FB0);
    chk("t3_count", tri_count, 2);

    // stray done / ack in idle change nothing
    c0 = m_cnt;
    f0 = m_front;
    rast_done = 1'b1;
    tick();
    rast_done = 1'b0;
    swap_ack  = 1'b1;
    tick();
    swap_ack  = 1'b0;
    tick();
    chk("t5_count", tri_count, c0);
    chk("t5_front", front_base, f0);
    chk("t5_busy", busy, 0);
    chk("t5_swap_req", swap_req, 0);

    // five pushes while rasterizer stalls, then drain in order
    started.delete();
    c0 = m_cnt;
    for (int i = 0; i < 5; i++) begin
      tri_valid = 1'b1;
      tri_data  = mk(i, i + 1, i + 2, i + 3, i + 4, i + 5, 24'h100 + i);
      exp_q.push_back(tri_data);
      tick();
    end
    tri_valid = 1'b0;
    chk("t2_full", tri_ready, 0);
    rast_done = 1'b1;
    for (int k = 0; k < 100 && busy; k++) tick();
    rast_done = 1'b0;
    chk("t2_drained", busy, 0);
    chk("t2_n_started", started.size(), 5);
    for (int i = 0; i < 5 && i < started.size(); i++)
      chk($sformatf("t2_order%0d", i), started[i], exp_q[i]);
    chk("t2_count", tri_count, c0 + 16'd5);

    // reset in RUN with three queued drops everything
    tri_valid = 1'b1;
    tri_data  = mk(7, 7, 8, 8, 9, 9, 24'h777);
    tick();
    tri_valid = 1'b0;
    wait_start("t4_start");
    tick();
    for (int i = 0; i < 3; i++) begin
      tri_valid = 1'b1;
      tri_data  = mk(20 + i, 20, 30, 30, 40, 40, i);
      tick();
    end
    tri_valid = 1'b0;
    do_reset();
    started.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("t4_no_start", started.size(), 0);

    // triangle with minX=700
    do_reset();
    started.delete();
    tri_valid = 1'b1;
    tri_data  = mk(700, 10, 720, 20, 710, 30, 24'h55);
    tick();
    tri_valid = 1'b0;
    rast_done = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rast_done = 1'b0;
`ifdef RAST_CLIP_EN
    chk("t6_no_start", started.size(), 0);
    chk("t6_cull", cull_count, 1);
`else
    chk("t6_started", started.size(), 1);
`endif
    chk("t6_count", tri_count, 1);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      tri_valid = 1'($urandom_range(0, 1));
      tri_data  = mk($urandom_range(0, 799), $urandom_range(0, 799),
                     $urandom_range(0, 799), $urandom_range(0, 799),
                     $urandom_range(0, 799), $urandom_range(0, 799),
                     int'($urandom & 24'hFFFFFF));
      tri_eof   = ($urandom_range(0, 4) == 0);
      rast_done = ($urandom_range(0, 2) == 0);
      swap_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
